pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, memory-stall hold, flush and an optional 2-entry skid buffer. It generalises the fixed MEM/WB latch into a reusable block for every inter-stage boundary (IF/ID … MEM/WB). Payload width and control-field width are configurable. Control bits are forced to zero whenever the output holds a bubble, so a stalled or flushed slot can never commit a register or memory write.

## Interface
Parameters:
- DATA_W, default 69: payload width. Carries data that is never killed, e.g. RDaddr + ALUresult + MEMdata = 5+32+32.
- CTRL_W, default 2: control width. These bits are zeroed on bubbles, e.g. {MemtoReg, RegWrite}.
- SKID, default 1: 1 adds a second (skid) entry and registers ready_o; 0 gives a single entry with combinational ready_o.

Ports:
- clk_i  in  1  clock. The only clock.
- rst_i  in  1  reset. Synchronous, active-low.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept this cycle.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control bits.
- stall_i  in  1  memory stall. While high, nothing leaves the stage.
- flush_i  in  1  discard all held entries and any same-cycle input.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- data_o  out  DATA_W  held payload.
- ctrl_o  out  CTRL_W  held control bits, or 0 when valid_o=0.

## Operation
Definitions:
- out_fire = valid_o & ready_i & ~stall_i
- in_fire = valid_i & ready_o & ~flush_i

States, encoded as occupancy: EMPTY (0), ONE (main entry full), TWO (main and skid full; only reachable when SKID=1).

Transitions, evaluated every clock edge in priority order:
- rst_i=0 → EMPTY.
- flush_i=1 → EMPTY. Same-cycle in_fire is dropped. flush_i overrides stall_i.
- EMPTY: in_fire → ONE, main ← input.
- ONE, in_fire & out_fire → ONE, main ← input.
- ONE, in_fire & ~out_fire → TWO when SKID=1, skid ← input. When SKID=0 this case cannot occur.
- ONE, ~in_fire & out_fire → EMPTY.
- TWO, out_fire → ONE, main ← skid. ready_o=0 in TWO, so no input is taken.
- All other cases hold.

Output and ready rules:
- valid_o = (state≠EMPTY). data_o = main.data. ctrl_o = valid_o ? main.ctrl : 0.
- SKID=1: ready_o = (state≠TWO). Registered; no combinational path from ready_i or stall_i.
- SKID=0: ready_o = ~valid_o | (ready_i & ~stall_i). Combinational.
- Data-path registers need no reset. Only the state register resets. ctrl_o is gated by valid_o, so it reads 0 after reset regardless of storage contents.

## Timing
- Latency is 1 cycle from in_fire to valid_o.
- Throughput is 1 entry/cycle while ready_i=1 and stall_i=0.
- Outputs after reset: valid_o=0, ctrl_o=0, ready_o=1. data_o is don't-care.
- stall_i=1 freezes main and skid. data_o and ctrl_o stay stable for the whole stall.
- The legacy "clear RegWrite on stall" behaviour is replaced by valid gating at the consumer. Write-back must qualify writes with valid_o.
- Reset asserted mid-operation:
  - The stage is EMPTY on the next edge; both entries are lost.
  - A held valid_i is not accepted during the reset cycle.
- Flush and stall together: flush wins, and the stage is EMPTY on the next edge.
- Upstream rule: once valid_i=1, data_i and ctrl_i must stay stable until ready_o=1. The block does not check this; verification asserts it.

## Structure
- Shared package pipe_pkg holds:
  - the occupancy enum (EMPTY, ONE, TWO), encoded 2'b00, 2'b01, 2'b10;
  - the localparams for the MEM/WB widths (WB_CTRL_W=2, WB_DATA_W=69), so each stage instance stays in step.
- One sub-module is natural: pipe_entry, a single DATA_W+CTRL_W register with a load enable. It is instantiated twice (main, skid), the skid instance under a generate on SKID.
- Expected size is about 150 lines total.

## Test plan
1. Reset and streaming (SKID=1):
   - rst_i=0 for 2 cycles → valid_o=0, ctrl_o=0, ready_o=1.
   - Then stream 0x1..0x8 with ready_i=1 → the same sequence appears on data_o one cycle later, gap-free.
2. Skid fill:
   - Hold ready_i=0 and send A, B → state TWO, ready_o=0 on the cycle after B, data_o=A.
   - Raise ready_i → data_o=A, then B. ready_o returns to 1 after A drains.
3. Stall hold:
   - Entry with ctrl=2'b11, data=0xDEAD, stall_i=1 for 5 cycles with ready_i=1 → data_o, ctrl_o and valid_o unchanged.
   - On release → consumed in 1 cycle.
4. Flush priority:
   - State TWO, plus valid_i=1, stall_i=1, flush_i=1 in the same cycle → next cycle valid_o=0, ctrl_o=0, ready_o=1.
   - The flushed input never appears on the output.
5. Mid-operation reset:
   - rst_i=0 while in TWO with valid_i=1 → EMPTY next edge.
   - After release, the first accepted entry is the one presented then.
6. SKID=0 build:
   - ready_i=0 with valid_o=1 → ready_o=0 in the same cycle.
   - ready_i=1 → simultaneous in/out each cycle, no bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and stage widths for every inter-stage pipeline register.
// Occupancy encoding doubles as the stage FSM state.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } occ_e;

    localparam int WB_CTRL_W = 2;
    localparam int WB_DATA_W = 69;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a plain load-enabled register holding {ctrl, data}.
module pipe_entry #(
    parameter int W = 71
) (
    input  logic         clk_i,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: payload storage has no reset; validity lives only in the state register.
    always_ff @(posedge clk_i) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall hold, flush and optional skid entry.
// Control bits are gated to zero whenever the stage presents a bubble.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int CTRL_W = WB_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    localparam int ENT_W = DATA_W + CTRL_W;

    occ_e             state_q, state_d;
    logic             out_fire, in_fire;
    logic             main_load, skid_load, main_from_skid;
    logic [ENT_W-1:0] main_d, main_q, skid_q;

    assign valid_o  = (state_q != EMPTY);
    assign out_fire = valid_o & ready_i & ~stall_i;
    assign in_fire  = valid_i & ready_o & ~flush_i;

    generate
        if (SKID != 0) begin : g_ready_reg
            assign ready_o = (state_q != TWO);
        end else begin : g_ready_comb
            assign ready_o = ~valid_o | (ready_i & ~stall_i);
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : {ctrl_i, data_i};

    pipe_entry #(.W(ENT_W)) u_main (
        .clk_i (clk_i),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(.W(ENT_W)) u_skid (
                .clk_i (clk_i),
                .load  (skid_load),
                .d     ({ctrl_i, data_i}),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign data_o = main_q[DATA_W-1:0];
    assign ctrl_o = valid_o ? main_q[ENT_W-1:DATA_W] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance checked against
// queue models every cycle, plus directed literal expectations.
module tb_pipe_stage_reg;

    localparam int DW = 69;
    localparam int CW = 2;
    localparam int EW = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;

    logic          a_valid_i, a_ready_o, a_stall_i, a_flush_i, a_valid_o, a_ready_i;
    logic [DW-1:0] a_data_i, a_data_o;
    logic [CW-1:0] a_ctrl_i, a_ctrl_o;

    logic          b_valid_i, b_ready_o, b_stall_i, b_flush_i, b_valid_o, b_ready_i;
    logic [DW-1:0] b_data_i, b_data_o;
    logic [CW-1:0] b_ctrl_i, b_ctrl_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut_skid (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .data_i  (a_data_i),
        .ctrl_i  (a_ctrl_i),
        .stall_i (a_stall_i),
        .flush_i (a_flush_i),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i),
        .data_o  (a_data_o),
        .ctrl_o  (a_ctrl_o)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut_noskid (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_i  (b_data_i),
        .ctrl_i  (b_ctrl_i),
        .stall_i (b_stall_i),
        .flush_i (b_flush_i),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .data_o  (b_data_o),
        .ctrl_o  (b_ctrl_o)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Models: a FIFO of held entries, capacity 2 (skid) or 1 (no skid).
    logic [EW-1:0] qa[$];
    logic [EW-1:0] qb[$];

    always @(posedge clk) begin : model_a
        bit rdy, ofire, ifire;
        rdy   = (qa.size() < 2);
        ofire = (qa.size() != 0) && a_ready_i && !a_stall_i;
        ifire = a_valid_i && rdy && !a_flush_i;
        if (!rst_i || a_flush_i) begin
            qa.delete();
        end else begin
            if (ofire) void'(qa.pop_front());
            if (ifire) qa.push_back({a_ctrl_i, a_data_i});
        end
    end

    always @(posedge clk) begin : model_b
        bit rdy, ofire, ifire;
        ofire = (qb.size() != 0) && b_ready_i && !b_stall_i;
        rdy   = (qb.size() == 0) || (b_ready_i && !b_stall_i);
        ifire = b_valid_i && rdy && !b_flush_i;
        if (!rst_i || b_flush_i) begin
            qb.delete();
        end else begin
            if (ofire) void'(qb.pop_front());
            if (ifire) qb.push_back({b_ctrl_i, b_data_i});
        end
    end

    always @(negedge clk) begin : compare
        logic [EW-1:0] ha, hb;
        if (cmp_en) begin
            ha = (qa.size() != 0) ? qa[0] : '0;
            hb = (qb.size() != 0) ? qb[0] : '0;
            check("m_a_valid", a_valid_o, qa.size() != 0);
            check("m_a_ready", a_ready_o, qa.size() < 2);
            check("m_a_ctrl", a_ctrl_o, ha[EW-1:DW]);
            if (qa.size() != 0) check("m_a_data", a_data_o, ha[DW-1:0]);
            check("m_b_valid", b_valid_o, qb.size() != 0);
            check("m_b_ready", b_ready_o, (qb.size() == 0) || (b_ready_i && !b_stall_i));
            check("m_b_ctrl", b_ctrl_o, hb[EW-1:DW]);
            if (qb.size() != 0) check("m_b_data", b_data_o, hb[DW-1:0]);
        end
    end

    initial begin
        rst_i     = 1'b0;
        a_valid_i = 1'b0; a_stall_i = 1'b0; a_flush_i = 1'b0; a_ready_i = 1'b1;
        a_data_i  = '0;   a_ctrl_i  = '0;
        b_valid_i = 1'b0; b_stall_i = 1'b0; b_flush_i = 1'b0; b_ready_i = 1'b1;
        b_data_i  = '0;   b_ctrl_i  = '0;

        // Reset for two cycles
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_valid", a_valid_o, 1'b0);
        check("rst_ctrl", a_ctrl_o, 2'b00);
        check("rst_ready", a_ready_o, 1'b1);
        check("rst_b_ready", b_ready_o, 1'b1);
        rst_i = 1'b1;

        // Gap-free streaming
        a_valid_i = 1'b1;
        a_ctrl_i  = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            a_data_i = DW'(i);
            tick();
            check("stream_data", a_data_o, 96'(i));
            check("stream_valid", a_valid_o, 1'b1);
        end
        a_valid_i = 1'b0;
        tick();
        check("stream_drain", a_valid_o, 1'b0);

        // Skid fill with downstream blocked
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 69'hA;
        tick();
        a_data_i  = 69'hB;
        tick();
        check("skid_ready", a_ready_o, 1'b0);
        check("skid_head", a_data_o, 96'hA);
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        #1;
        check("skid_ready_registered", a_ready_o, 1'b0);
        tick();
        check("skid_second", a_data_o, 96'hB);
        check("skid_ready_back", a_ready_o, 1'b1);
        tick();
        check("skid_empty", a_valid_o, 1'b0);

        // Stall hold
        a_stall_i = 1'b1;
        a_valid_i = 1'b1;
        a_ctrl_i  = 2'b11;
        a_data_i  = 69'hDEAD;
        tick();
        a_valid_i = 1'b0;
        repeat (5) begin
            check("stall_data", a_data_o, 96'hDEAD);
            check("stall_ctrl", a_ctrl_o, 2'b11);
            check("stall_valid", a_valid_o, 1'b1);
            tick();
        end
        a_stall_i = 1'b0;
        tick();
        check("stall_release_valid", a_valid_o, 1'b0);
        check("stall_release_ctrl", a_ctrl_o, 2'b00);

        // Flush beats stall and same-cycle input
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_ctrl_i  = 2'b01;
        a_data_i  = 69'h11;
        tick();
        a_data_i  = 69'h22;
        tick();
        check("flush_pre_two", a_ready_o, 1'b0);
        a_data_i  = 69'h33;
        a_ctrl_i  = 2'b11;
        a_stall_i = 1'b1;
        a_flush_i = 1'b1;
        tick();
        check("flush_valid", a_valid_o, 1'b0);
        check("flush_ctrl", a_ctrl_o, 2'b00);
        check("flush_ready", a_ready_o, 1'b1);
        a_flush_i = 1'b0;
        a_stall_i = 1'b0;
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        repeat (3) begin
            tick();
            check("flush_dropped", a_valid_o, 1'b0);
        end

        // Mid-operation reset while full
        a_ready_i = 1'b0;
        a_valid_i = 1'b1;
        a_ctrl_i  = 2'b01;
        a_data_i  = 69'h44;
        tick();
        a_data_i  = 69'h55;
        tick();
        check("mrst_pre_two", a_ready_o, 1'b0);
        a_data_i  = 69'h66;
        rst_i     = 1'b0;
        tick();
        check("mrst_valid", a_valid_o, 1'b0);
        check("mrst_ready", a_ready_o, 1'b1);
        rst_i     = 1'b1;
        a_data_i  = 69'h77;
        a_ctrl_i  = 2'b10;
        tick();
        check("mrst_first_valid", a_valid_o, 1'b1);
        check("mrst_first_data", a_data_o, 96'h77);
        check("mrst_first_ctrl", a_ctrl_o, 2'b10);
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        tick();
        check("mrst_drain", a_valid_o, 1'b0);

        // Single-entry build: combinational ready
        b_ready_i = 1'b0;
        b_valid_i = 1'b1;
        b_ctrl_i  = 2'b01;
        b_data_i  = 69'h99;
        tick();
        b_valid_i = 1'b0;
        #1;
        check("ns_valid", b_valid_o, 1'b1);
        check("ns_ctrl", b_ctrl_o, 2'b01);
        check("ns_ready_low", b_ready_o, 1'b0);
        b_ready_i = 1'b1;
        b_valid_i = 1'b1;
        b_data_i  = 69'h100;
        #1;
        check("ns_ready_comb", b_ready_o, 1'b1);
        for (int v = 'h100; v <= 'h104; v++) begin
            b_data_i = DW'(v);
            tick();
            check("ns_stream_data", b_data_o, 96'(v));
            check("ns_stream_valid", b_valid_o, 1'b1);
        end
        b_valid_i = 1'b0;
        tick();
        check("ns_drain", b_valid_o, 1'b0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
